// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - bus bundle between the CPU control unit, the program loader, the memory and the arbiter
//
// Signals:
//   CpuReq/CpuWe/CpuAddr/CpuWdata -> arbiter   control unit access request
//   CpuAck/CpuRdata/CpuWait       <- arbiter   control unit completion, read data, stall
//   LdReq/LdWe/LdAddr/LdWdata     -> arbiter   loader access request
//   LdAck/LdRdata                 <- arbiter   loader completion and read data
//   MemEn/MemWe/MemAddr/MemWdata  <- arbiter   memory array strobes
//   MemRdata                      -> arbiter   memory array read data
//   Owner/Busy                    <- arbiter   current owner and access-in-progress flag
// Modports: slave = arbiter side, master = requesters/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              CpuReq;
    logic              CpuWe;
    logic [ADDR_W-1:0] CpuAddr;
    logic [DATA_W-1:0] CpuWdata;
    logic              CpuAck;
    logic [DATA_W-1:0] CpuRdata;
    logic              CpuWait;

    logic              LdReq;
    logic              LdWe;
    logic [ADDR_W-1:0] LdAddr;
    logic [DATA_W-1:0] LdWdata;
    logic              LdAck;
    logic [DATA_W-1:0] LdRdata;

    logic              MemEn;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWdata;
    logic [DATA_W-1:0] MemRdata;

    logic              Owner;
    logic              Busy;

    modport slave (
        input  CpuReq, CpuWe, CpuAddr, CpuWdata,
        output CpuAck, CpuRdata, CpuWait,
        input  LdReq, LdWe, LdAddr, LdWdata,
        output LdAck, LdRdata,
        output MemEn, MemWe, MemAddr, MemWdata,
        input  MemRdata,
        output Owner, Busy
    );

    modport master (
        output CpuReq, CpuWe, CpuAddr, CpuWdata,
        input  CpuAck, CpuRdata, CpuWait,
        output LdReq, LdWe, LdAddr, LdWdata,
        input  LdAck, LdRdata,
        input  MemEn, MemWe, MemAddr, MemWdata,
        output MemRdata,
        input  Owner, Busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter for the single-port program/data memory (CPU vs loader)
//
// Ports:
//   CLOCK  in   system clock, rising edge
//   RESET  in   asynchronous active-low reset
//   bus    slave modport of mem_arbiter_if (requester handshakes, memory strobes, Owner/Busy)
// Sequencer: IDLE -> ACCESS (WAIT_CYCLES cycles, MemEn high) -> DONE (Ack pulse) -> IDLE.
module mem_arbiter #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          CLOCK,
    input  logic          RESET,
    mem_arbiter_if.slave  bus
);

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("mem_arbiter: WAIT_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic              last_ld, last_ld_n;   // 1 = loader was served last
    logic              owner, owner_n;
    logic              busy, busy_n;
    logic              mem_en, mem_en_n;
    logic              mem_we, mem_we_n;
    logic [ADDR_W-1:0] mem_addr, mem_addr_n;
    logic [DATA_W-1:0] mem_wdata, mem_wdata_n;
    logic              cpu_ack, cpu_ack_n;
    logic              ld_ack, ld_ack_n;
    logic [DATA_W-1:0] cpu_rdata, cpu_rdata_n;
    logic [DATA_W-1:0] ld_rdata, ld_rdata_n;
    logic              grant_ld;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            last_ld   <= 1'b1;
            owner     <= 1'b0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            ld_ack    <= 1'b0;
            cpu_rdata <= '0;
            ld_rdata  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            last_ld   <= last_ld_n;
            owner     <= owner_n;
            busy      <= busy_n;
            mem_en    <= mem_en_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            cpu_ack   <= cpu_ack_n;
            ld_ack    <= ld_ack_n;
            cpu_rdata <= cpu_rdata_n;
            ld_rdata  <= ld_rdata_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        last_ld_n   = last_ld;
        owner_n     = owner;
        busy_n      = busy;
        mem_en_n    = mem_en;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        cpu_ack_n   = 1'b0;
        ld_ack_n    = 1'b0;
        cpu_rdata_n = cpu_rdata;
        ld_rdata_n  = ld_rdata;
        // Loader wins when it is alone, or on a tie when the CPU was served last.
        grant_ld    = bus.LdReq & (~bus.CpuReq | ~last_ld);

        case (state)
            ST_IDLE: begin
                if (bus.CpuReq || bus.LdReq) begin
                    owner_n     = grant_ld;
                    busy_n      = 1'b1;
                    mem_en_n    = 1'b1;
                    mem_we_n    = grant_ld ? bus.LdWe    : bus.CpuWe;
                    mem_addr_n  = grant_ld ? bus.LdAddr  : bus.CpuAddr;
                    mem_wdata_n = grant_ld ? bus.LdWdata : bus.CpuWdata;
                    cnt_n       = CNT_INIT;
                    state_n     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt == 4'd0) begin
                    // Last access cycle: MemRdata is valid now; writes leave Rdata alone.
                    if (owner) begin
                        ld_ack_n = 1'b1;
                        if (!mem_we) ld_rdata_n = bus.MemRdata;
                    end else begin
                        cpu_ack_n = 1'b1;
                        if (!mem_we) cpu_rdata_n = bus.MemRdata;
                    end
                    mem_en_n  = 1'b0;
                    mem_we_n  = 1'b0;
                    last_ld_n = owner;
                    state_n   = ST_DONE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            ST_DONE: begin
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            default: begin
                busy_n   = 1'b0;
                mem_en_n = 1'b0;
                mem_we_n = 1'b0;
                state_n  = ST_IDLE;
            end
        endcase
    end

    assign bus.CpuAck   = cpu_ack;
    assign bus.CpuRdata = cpu_rdata;
    assign bus.CpuWait  = bus.CpuReq & ~cpu_ack;
    assign bus.LdAck    = ld_ack;
    assign bus.LdRdata  = ld_rdata;
    assign bus.MemEn    = mem_en;
    assign bus.MemWe    = mem_we;
    assign bus.MemAddr  = mem_addr;
    assign bus.MemWdata = mem_wdata;
    assign bus.Owner    = owner;
    assign bus.Busy     = busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (WAIT_CYCLES = 2)
module tb_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;

    logic CLOCK = 1'b0;
    logic RESET = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mem [0:31];

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLOCK = ~CLOCK;

    assign bus.MemRdata = mem[bus.MemAddr];

    always @(posedge CLOCK) begin
        if (bus.MemEn && bus.MemWe) mem[bus.MemAddr] <= bus.MemWdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " CpuAck"},   32'(bus.CpuAck),   0);
        check({tag, " LdAck"},    32'(bus.LdAck),    0);
        check({tag, " MemEn"},    32'(bus.MemEn),    0);
        check({tag, " MemWe"},    32'(bus.MemWe),    0);
        check({tag, " MemAddr"},  32'(bus.MemAddr),  0);
        check({tag, " MemWdata"}, 32'(bus.MemWdata), 0);
        check({tag, " CpuRdata"}, 32'(bus.CpuRdata), 0);
        check({tag, " LdRdata"},  32'(bus.LdRdata),  0);
        check({tag, " Owner"},    32'(bus.Owner),    0);
        check({tag, " Busy"},     32'(bus.Busy),     0);
    endtask

    task automatic clear_reqs();
        bus.CpuReq = 0; bus.CpuWe = 0; bus.CpuAddr = '0; bus.CpuWdata = '0;
        bus.LdReq  = 0; bus.LdWe  = 0; bus.LdAddr  = '0; bus.LdWdata  = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 3);
        mem[5'h0A] = 8'h3C;
        mem[5'h03] = 8'h77;

        // Reset with random requester inputs
        RESET = 0;
        bus.CpuReq = 1'($urandom); bus.CpuWe = 1'($urandom);
        bus.CpuAddr = 5'($urandom); bus.CpuWdata = 8'($urandom);
        bus.LdReq = 1'($urandom); bus.LdWe = 1'($urandom);
        bus.LdAddr = 5'($urandom); bus.LdWdata = 8'($urandom);
        tick();
        tick();
        check_idle_outputs("reset");
        check("reset CpuWait", 32'(bus.CpuWait), 32'(bus.CpuReq));
        clear_reqs();
        RESET = 1;
        tick();
        tick();
        check_idle_outputs("post-reset");

        // CPU read of 0x0A, with an address change mid-access
        bus.CpuReq = 1; bus.CpuWe = 0; bus.CpuAddr = 5'h0A;
        #1;
        check("rd wait before grant", 32'(bus.CpuWait), 1);
        tick();
        check("rd acc1 MemEn",   32'(bus.MemEn),   1);
        check("rd acc1 MemAddr", 32'(bus.MemAddr), 32'h0A);
        check("rd acc1 MemWe",   32'(bus.MemWe),   0);
        check("rd acc1 Owner",   32'(bus.Owner),   0);
        check("rd acc1 Busy",    32'(bus.Busy),    1);
        check("rd acc1 CpuWait", 32'(bus.CpuWait), 1);
        bus.CpuAddr = 5'h15;
        tick();
        check("rd acc2 MemEn",   32'(bus.MemEn),   1);
        check("rd acc2 MemAddr frozen", 32'(bus.MemAddr), 32'h0A);
        check("rd acc2 CpuAck",  32'(bus.CpuAck),  0);
        tick();
        check("rd done CpuAck",   32'(bus.CpuAck),   1);
        check("rd done CpuRdata", 32'(bus.CpuRdata), 32'h3C);
        check("rd done MemEn",    32'(bus.MemEn),    0);
        check("rd done CpuWait",  32'(bus.CpuWait),  0);
        check("rd done Busy",     32'(bus.Busy),     1);
        check("rd done LdAck",    32'(bus.LdAck),    0);
        bus.CpuReq = 0;
        tick();
        check("rd idle CpuAck", 32'(bus.CpuAck), 0);
        check("rd idle Busy",   32'(bus.Busy),   0);

        // Loader write of 0xA5 to 0x1F
        bus.LdReq = 1; bus.LdWe = 1; bus.LdAddr = 5'h1F; bus.LdWdata = 8'hA5;
        tick();
        check("wr acc1 MemWe",    32'(bus.MemWe),    1);
        check("wr acc1 MemAddr",  32'(bus.MemAddr),  32'h1F);
        check("wr acc1 MemWdata", 32'(bus.MemWdata), 32'hA5);
        check("wr acc1 Owner",    32'(bus.Owner),    1);
        tick();
        check("wr acc2 MemWe",    32'(bus.MemWe),    1);
        check("wr acc2 LdAck",    32'(bus.LdAck),    0);
        tick();
        check("wr done LdAck",    32'(bus.LdAck),    1);
        check("wr done CpuAck",   32'(bus.CpuAck),   0);
        check("wr done MemWe",    32'(bus.MemWe),    0);
        check("wr done LdRdata",  32'(bus.LdRdata),  0);
        check("wr done CpuRdata held", 32'(bus.CpuRdata), 32'h3C);
        bus.LdReq = 0; bus.LdWe = 0;
        tick();
        check("wr idle LdAck", 32'(bus.LdAck), 0);
        check("wr mem[1F]",    32'(mem[5'h1F]), 32'hA5);

        // Simultaneous requests out of reset: alternate CPU, loader, CPU, loader
        RESET = 0;
        tick();
        RESET = 1;
        bus.CpuReq = 1; bus.CpuWe = 0; bus.CpuAddr = 5'h0A;
        bus.LdReq  = 1; bus.LdWe  = 0; bus.LdAddr  = 5'h03;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rr%0d Owner", k), 32'(bus.Owner), 32'(k % 2));
            check($sformatf("rr%0d Busy", k),  32'(bus.Busy),  1);
            tick();
            tick();
            check($sformatf("rr%0d CpuAck", k), 32'(bus.CpuAck), 32'((k % 2) == 0));
            check($sformatf("rr%0d LdAck", k),  32'(bus.LdAck),  32'((k % 2) == 1));
            tick();
        end
        check("rr CpuRdata", 32'(bus.CpuRdata), 32'h3C);
        check("rr LdRdata",  32'(bus.LdRdata),  32'h77);
        clear_reqs();
        tick();
        tick();

        // Reset in the first ACCESS cycle, then re-grant of the held request
        bus.CpuReq = 1; bus.CpuWe = 0; bus.CpuAddr = 5'h0A;
        tick();
        check("mr acc1 MemEn", 32'(bus.MemEn), 1);
        RESET = 0;
        #1;
        check("mr MemEn",  32'(bus.MemEn),  0);
        check("mr Busy",   32'(bus.Busy),   0);
        check("mr CpuAck", 32'(bus.CpuAck), 0);
        check("mr LdAck",  32'(bus.LdAck),  0);
        tick();
        tick();
        check("mr held CpuAck", 32'(bus.CpuAck), 0);
        check("mr held Busy",   32'(bus.Busy),   0);
        RESET = 1;
        tick();
        check("mr regrant MemEn",   32'(bus.MemEn),   1);
        check("mr regrant MemAddr", 32'(bus.MemAddr), 32'h0A);
        check("mr regrant Owner",   32'(bus.Owner),   0);
        tick();
        tick();
        check("mr regrant CpuAck",   32'(bus.CpuAck),   1);
        check("mr regrant CpuRdata", 32'(bus.CpuRdata), 32'h3C);
        bus.CpuReq = 0;
        tick();
        check("mr final Busy", 32'(bus.Busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single-port program/data memory between two requesters: the processor control unit (instruction fetch, operand read, MemWr store) and the host program loader (writes/verifies program images).
- Sits between the control unit's memory-access strobes and the memory array.
- Runs a 3-state access sequencer with a configurable wait-state count and round-robin fairness.
- Stalls the control unit (CpuWait) while its access is pending.

Parameters:
- ADDR_W, 5, memory address width (instruction operand field)
- DATA_W, 8, memory data width (instruction/accumulator width)
- WAIT_CYCLES, 1, memory latency in cycles; legal range 1..15

Ports:
- CLOCK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- CpuReq  in  1  control unit access request; held until CpuAck
- CpuWe  in  1  1 = write (MemWr), 0 = read
- CpuAddr  in  ADDR_W  control unit address
- CpuWdata  in  DATA_W  control unit write data
- CpuAck  out  1  one-cycle completion pulse
- CpuRdata  out  DATA_W  read data; valid while CpuAck = 1
- CpuWait  out  1  stall to control unit = CpuReq & ~CpuAck (combinational)
- LdReq  in  1  loader request; held until LdAck
- LdWe  in  1  loader write enable
- LdAddr  in  ADDR_W  loader address
- LdWdata  in  DATA_W  loader write data
- LdAck  out  1  one-cycle completion pulse
- LdRdata  out  DATA_W  read data; valid while LdAck = 1
- MemEn  out  1  memory enable
- MemWe  out  1  memory write enable
- MemAddr  out  ADDR_W  memory address
- MemWdata  out  DATA_W  memory write data
- MemRdata  in  DATA_W  memory read data; valid in the last ACCESS cycle
- Owner  out  1  0 = CPU, 1 = loader; meaningful only while Busy = 1
- Busy  out  1  access in progress (ACCESS or DONE)

Behaviour:
- Reset (RESET = 0, asynchronous):
  - State = IDLE.
  - All outputs 0: CpuAck, LdAck, MemEn, MemWe, MemAddr, MemWdata, CpuRdata, LdRdata, Owner, Busy.
  - Wait counter = 0.
  - Last-served pointer = loader, so the CPU wins the first tie.
- States:
  - IDLE: sample requests at each rising edge.
    - One request high: grant it.
    - Both high: grant the requester that is not the last-served one.
    - Neither high: stay in IDLE.
    - On grant: latch the winner's We/Addr/Wdata into MemWe/MemAddr/MemWdata, set MemEn = 1, Owner, Busy = 1, counter = WAIT_CYCLES-1, then go to ACCESS.
  - ACCESS: MemEn held at 1; memory outputs stay stable and are frozen against requester input changes. Decrement the counter each cycle; when counter = 0:
    - Capture MemRdata into the owner's Rdata register.
    - Assert the owner's Ack for one cycle.
    - Drop MemEn and MemWe.
    - Update the last-served pointer to Owner.
    - Go to DONE.
  - DONE: Ack = 1 for exactly this cycle; Busy = 1. Go to IDLE unconditionally; Ack = 0 next cycle.
- Latency: request sampled at edge N gives MemEn high for cycles N+1..N+WAIT_CYCLES and Ack high in cycle N+WAIT_CYCLES+1. Throughput is one access per WAIT_CYCLES+2 cycles.
- Ack deassertion: the requester must drop or change Req in the cycle after Ack. A Req still high in IDLE is treated as a new request.
- Rdata registers hold their value until the next read by the same owner. Writes leave the Rdata registers unchanged.
- Fairness: with both requesters held high continuously, grants alternate CPU, loader, CPU, and so on. Neither requester waits more than one foreign access.
- A request deasserted before its Ack (protocol violation): the access still completes and Ack still pulses. The memory write, if any, occurs.
- A request arriving during ACCESS/DONE is not sampled until IDLE.
- Reset mid-access: immediate return to IDLE with all outputs 0. The interrupted write may or may not have been committed to memory; no Ack is issued.
- WAIT_CYCLES outside 1..15 is illegal; the implementation flags it with an elaboration-time error.

Test Plan:
- Reset values: hold RESET = 0 for 2 edges with random inputs -> every output 0, state IDLE; release -> outputs stay 0 with no request.
- CPU read: WAIT_CYCLES = 2, CpuReq = 1, CpuWe = 0, CpuAddr = 5'h0A, memory returns 8'h3C -> MemEn high for 2 cycles with MemAddr = 0A; CpuAck = 1 with CpuRdata = 3C in the 3rd cycle after the sampling edge; CpuWait high from request until Ack.
- Loader write: LdReq = 1, LdWe = 1, LdAddr = 5'h1F, LdWdata = 8'hA5 -> MemWe = 1, MemAddr = 1F, MemWdata = A5 during ACCESS; LdAck pulses once; CpuAck stays 0.
- Simultaneous requests out of reset -> CPU granted first; both held for 4 accesses -> Owner sequence 0, 1, 0, 1.
- Input change mid-access: change CpuAddr from 0A to 15 during ACCESS -> MemAddr stays 0A until DONE.
- Reset mid-access: assert RESET in the 1st ACCESS cycle -> MemEn, Busy, and all Acks drop at once, no Ack pulse; after release a held CpuReq is re-granted normally.
